// File: rtl/rng_range_scheduler.sv
// -----------------------------------------------------------------------------
// rng_range_scheduler
//
// Shared random-number service for the game logic. A free-running 16-bit
// Galois LFSR feeds a single serial range reducer that is time-shared between
// N_REQ clients in round-robin order. Each client asks for a value in [lo,hi].
// Modulo bias is removed by rejection sampling: a raw draw that falls in the
// incomplete top "bucket" of the 16-bit space is thrown away and redrawn. After
// MAX_RETRY rejections the next draw is accepted as is, which bounds latency.
//
// Ports
//   clk       in   1         system clock, all logic on posedge
//   reset     in   1         synchronous, active-high
//   req       in   N_REQ     request per client, held high until done
//   min_bus   in   16*N_REQ  client i lower bound at [16i+15:16i]
//   max_bus   in   16*N_REQ  client i upper bound at [16i+15:16i]
//   done      out  N_REQ     one-cycle pulse to the served client
//   rand_out  out  16        last delivered result, held until the next done
//   busy      out  1         high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module rng_range_scheduler #(
    parameter int          N_REQ     = 2,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_RETRY = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   min_bus,
    input  logic [16*N_REQ-1:0]   max_bus,
    output logic [N_REQ-1:0]      done,
    output logic [15:0]           rand_out,
    output logic                  busy
);

    localparam int          PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          RW       = $clog2(MAX_RETRY + 1);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        DIV,
        CHECK,
        DONE
    } state_t;

    state_t         state;
    logic [15:0]    lfsr;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  g;
    logic [RW-1:0]  retry;
    logic [3:0]     div_cnt;

    logic [15:0]    lo;
    logic [16:0]    total;      // hi-lo+1, can be 65536
    logic [15:0]    r;          // raw draw, kept for the acceptance test
    logic [15:0]    r_shift;    // dividend bits consumed MSB first
    logic [15:0]    rem;        // always < total, so 16 bits suffice

    logic           grant_valid;
    logic [PW-1:0]  grant_idx;
    logic [PW:0]    scan;
    logic [15:0]    sel_min;
    logic [15:0]    sel_max;
    logic [15:0]    lo_sel;
    logic [15:0]    hi_sel;
    logic [16:0]    trial;
    logic           accept;

    // Round-robin pick: scan from the highest offset down so that the lowest
    // offset from rr_ptr, i.e. the next client in turn, is the one that sticks.
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(N_REQ))
                scan = scan - (PW+1)'(N_REQ);
            if (req[scan[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan[PW-1:0];
            end
        end

        sel_min = '0;
        sel_max = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_min = min_bus[16*i +: 16];
                sel_max = max_bus[16*i +: 16];
            end
        end

        // Clients may hand over the bounds in either order.
        lo_sel = (sel_min <= sel_max) ? sel_min : sel_max;
        hi_sel = (sel_min <= sel_max) ? sel_max : sel_min;
    end

    // One restoring-division step: shift in the next dividend bit, subtract
    // the divisor when it fits.
    assign trial  = {rem, r_shift[15]};

    // r - rem is the start of r's bucket; the bucket is complete (unbiased)
    // only if it ends inside the 16-bit space.
    assign accept = (({1'b0, r} - {1'b0, rem}) + total) <= 17'h10000;

    assign busy   = (state != IDLE);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    // NOTE: the datapath registers (lo, total, r, r_shift, rem, div_cnt, g)
    // are deliberately not reset; each is loaded before it is ever read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lfsr     <= SEED_EFF;
            rr_ptr   <= '0;
            retry    <= '0;
            done     <= '0;
            rand_out <= '0;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
            done <= '0;

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        g     <= grant_idx;
                        lo    <= lo_sel;
                        total <= {1'b0, hi_sel} - {1'b0, lo_sel} + 17'd1;
                        state <= DRAW;
                    end
                end

                DRAW: begin
                    if (!req[g]) begin
                        retry <= '0;
                        state <= IDLE;
                    end else begin
                        r       <= lfsr;
                        r_shift <= lfsr;
                        rem     <= '0;
                        div_cnt <= '0;
                        state   <= DIV;
                    end
                end

                DIV: begin
                    if (!req[g]) begin
                        retry <= '0;
                        state <= IDLE;
                    end else begin
                        rem     <= (trial >= total) ? 16'(trial - total) : trial[15:0];
                        r_shift <= r_shift << 1;
                        div_cnt <= div_cnt + 4'd1;
                        if (div_cnt == 4'd15)
                            state <= CHECK;
                    end
                end

                CHECK: begin
                    if (!req[g]) begin
                        retry <= '0;
                        state <= IDLE;
                    end else if (accept || retry == RW'(MAX_RETRY)) begin
                        rand_out <= lo + rem;
                        retry    <= '0;
                        state    <= DONE;
                    end else begin
                        retry <= retry + RW'(1);
                        state <= DRAW;
                    end
                end

                DONE: begin
                    done[g] <= 1'b1;
                    rr_ptr  <= (g == PW'(N_REQ - 1)) ? '0 : g + PW'(1);
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_range_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rng_range_scheduler
//
// Randomized bench for rng_range_scheduler. A reference LFSR steps alongside
// the DUT and records its value after every clock edge; expected results and
// done times are then derived from the draw/reject/accept rules with plain
// integer arithmetic over that history.
// -----------------------------------------------------------------------------
module tb_rng_range_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [31:0] min_bus = '0;
    logic [31:0] max_bus = '0;
    logic [1:0]  done;
    logic [15:0] rand_out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rng_range_scheduler #(
        .N_REQ     (2),
        .SEED      (16'hACE1),
        .MAX_RETRY (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .min_bus  (min_bus),
        .max_bus  (max_bus),
        .done     (done),
        .rand_out (rand_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR: hist[k] is the LFSR value after edge k.
    int          cyc = 0;
    logic [15:0] m_lfsr;
    logic [15:0] hist [0:131071];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v[0])
            return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    always @(posedge clk) begin
        m_lfsr      <= reset ? 16'hACE1 : lfsr_next(m_lfsr);
        hist[cyc+1] <= reset ? 16'hACE1 : lfsr_next(m_lfsr);
        cyc         <= cyc + 1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of a transaction granted at edge grant_edge.
    task automatic model_serve(input int grant_edge, input int a, input int b,
                               output int done_edge, output int val, output int rejects);
        int lo, hi, total, limit, d, r;
        lo      = (a <= b) ? a : b;
        hi      = (a <= b) ? b : a;
        total   = hi - lo + 1;
        limit   = (65536 / total) * total;
        d       = grant_edge + 1;
        rejects = 0;
        while (1) begin
            r = int'(hist[d-1]);
            if (r < limit || rejects == 8)
                break;
            rejects++;
            d += 18;
        end
        done_edge = d + 18;
        val       = lo + (r % total);
    endtask

    task automatic wait_done(input int budget, output int at, output logic [1:0] which);
        at    = -1;
        which = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done != 2'b00) begin
                at    = cyc;
                which = done;
                return;
            end
        end
    endtask

    // One complete single-client transaction with all checks.
    task automatic serve(input int c, input int mn, input int mx, output int got);
        int          e, at, exp_edge, exp_val, rej;
        logic [1:0]  which;
        tick();
        e = cyc;
        min_bus[c*16 +: 16] = 16'(mn);
        max_bus[c*16 +: 16] = 16'(mx);
        req[c] = 1'b1;
        wait_done(300, at, which);
        req[c] = 1'b0;
        got = int'(rand_out);
        model_serve(e + 1, mn, mx, exp_edge, exp_val, rej);
        chk("done_edge", at, exp_edge);
        chk("done_who", which, 2'b01 << c);
        chk("rand_out", rand_out, exp_val);
        tick();
        chk("done_pulse", done, 0);
    endtask

    int vals[4];
    int hist_bin[4];
    int v, e, at, exp_edge, exp_val, rej, held, nd;
    logic [1:0] which;
    logic [15:0] saved;

    initial begin
        // Reset held for 3 cycles.
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rand", rand_out, 0);
        reset = 1'b0;
        tick();

        // Small range 0..8.
        for (int i = 0; i < 6; i++) begin
            serve(0, 0, 8, v);
            chk("range_0_8", (v <= 8), 1);
        end

        // Single-value range.
        serve(1, 5, 5, v);
        chk("const_5", v, 5);

        // Full range returns the raw draw.
        for (int i = 0; i < 3; i++) serve(0, 0, 65535, v);

        // Swapped bounds.
        for (int i = 0; i < 4; i++) begin
            serve(1, 10, 3, v);
            chk("range_3_10", (v >= 3 && v <= 10), 1);
        end

        // Random bounds and clients.
        for (int i = 0; i < 30; i++) begin
            int a, b, c;
            c = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            serve(c, a, b, v);
            chk("range_rand", (v >= ((a < b) ? a : b) && v <= ((a < b) ? b : a)), 1);
        end

        // Abort: drop req[0] in DIV cycle 7.
        saved = rand_out;
        tick();
        e = cyc;
        min_bus[15:0] = 16'd0;
        max_bus[15:0] = 16'd8;
        req[0] = 1'b1;
        repeat (8) tick();
        chk("abort_busy_before", busy, 1);
        req[0] = 1'b0;
        tick();
        chk("abort_busy_after", busy, 0);
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done != 2'b00) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_rand_kept", rand_out, saved);

        // Reset in DIV cycle 5.
        tick();
        req[0] = 1'b1;
        repeat (6) tick();
        chk("midrst_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rand", rand_out, 0);
        reset  = 1'b0;
        req[0] = 1'b0;
        tick();
        serve(0, 0, 8, v);

        // 1000 draws over 0..39999: rejection timing and distribution.
        hist_bin = '{default: 0};
        for (int i = 0; i < 1000; i++) begin
            serve(0, 0, 39999, v);
            if (v < 40000) hist_bin[v / 10000]++;
            else           chk("range_40000", v, 0);
        end
        for (int b = 0; b < 4; b++)
            chk($sformatf("hist_bin%0d_flat", b),
                (hist_bin[b] >= 150 && hist_bin[b] <= 350), 1);

        // Both clients held from reset: grants alternate 0,1,0,1.
        min_bus = {16'd199, 16'd0};
        max_bus = {16'd100, 16'd8};
        req     = 2'b11;
        reset   = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        e = cyc + 1;                       // first edge with reset low grants
        for (int k = 0; k < 4; k++) begin
            int c;
            c = k % 2;
            wait_done(300, at, which);
            model_serve(e, (c == 0) ? 0 : 199, (c == 0) ? 8 : 100, exp_edge, exp_val, rej);
            chk("rr_edge", at, exp_edge);
            chk("rr_who", which, 2'b01 << c);
            chk("rr_rand", rand_out, exp_val);
            chk("rr_idle_gap", busy, 0);
            e = at + 1;
        end
        req = 2'b00;
        tick();
        chk("rr_done_clear", done, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
